// File: rtl/ipu_window_sequencer_pkg.sv
// Shared definitions for the window sequencer: opcodes,
// FSM states, window geometry and tap index helpers.
package ipu_window_sequencer_pkg;

  localparam logic [3:0] OP_CONV      = 4'b0101;
  localparam logic [3:0] OP_CONV_TRSP = 4'b0110;
  localparam logic [3:0] OP_CONV_ROB  = 4'b0111;
  localparam logic [3:0] OP_B2G       = 4'b1000;

  localparam int WIN_N    = 5;
  localparam int WIN_TAPS = WIN_N * WIN_N;
  localparam int WIN_BITS = 8 * WIN_TAPS;
  localparam int TAP_LAST = WIN_TAPS - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATHER,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_NEXT,
    S_DONE
  } state_t;

  function automatic logic op_valid(
    input logic [3:0] op
  );
    return op inside {
      OP_CONV, OP_CONV_TRSP,
      OP_CONV_ROB, OP_B2G
    };
  endfunction

  function automatic logic [2:0] tap_row(
    input logic [4:0] k
  );
    return 3'(k / 5'd5);
  endfunction

  function automatic logic [2:0] tap_col(
    input logic [4:0] k
  );
    return 3'(k % 5'd5);
  endfunction

endpackage

// File: rtl/ipu_window_sequencer_tap_addr_gen.sv
// Maps a centre pixel (x,y) and window tap k to the tap's
// in-image flag and raster address (combinational).
module ipu_tap_addr_gen
  import ipu_window_sequencer_pkg::*;
#(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int ADDR_W = 15,
  parameter int XW     = 8,
  parameter int YW     = 7
) (
  input  logic [XW-1:0]     x,
  input  logic [YW-1:0]     y,
  input  logic [4:0]        k,
  output logic              in_bounds,
  output logic [ADDR_W-1:0] addr
);

  localparam int SXW = XW + 2;
  localparam int SYW = YW + 2;

  logic [2:0] r;
  logic [2:0] c;

  // Coordinates are biased by +2 so the tap offset
  // (-2..+2) stays non-negative and x-2 cannot alias.
  logic [SXW-1:0] bx;
  logic [SYW-1:0] by;
  logic [SXW-1:0] px;
  logic [SYW-1:0] py;
  logic           x_ok;
  logic           y_ok;

  assign r = tap_row(k);
  assign c = tap_col(k);

  assign bx = {2'b00, x} + SXW'(c);
  assign by = {2'b00, y} + SYW'(r);

  assign x_ok = (bx >= SXW'(2))
             && (bx < SXW'(IMG_W + 2));
  assign y_ok = (by >= SYW'(2))
             && (by < SYW'(IMG_H + 2));

  assign px = bx - SXW'(2);
  assign py = by - SYW'(2);

  assign in_bounds = x_ok && y_ok;
  assign addr = ADDR_W'(py) * ADDR_W'(IMG_W)
              + ADDR_W'(px);

endmodule

// File: rtl/ipu_window_sequencer.sv
// Raster-walks a source image, gathers a zero-padded 5x5
// window per pixel, runs it through the coprocessor and
// writes the result byte to the destination image.
// Ports: start/op_sel/kernel frame control; src_* pixel
// read port; dst_* write port; cop_* coprocessor link;
// busy/frame_done/op_error status.
module ipu_window_sequencer
  import ipu_window_sequencer_pkg::*;
#(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int ADDR_W = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [3:0]          op_sel,
  input  logic [WIN_BITS-1:0] kernel,
  output logic [ADDR_W-1:0]   src_addr,
  input  logic [7:0]          src_data,
  output logic [ADDR_W-1:0]   dst_addr,
  output logic [7:0]          dst_data,
  output logic                dst_we,
  output logic [31:0]         cop_instr,
  output logic                cop_activate,
  output logic                cop_request,
  output logic [WIN_BITS-1:0] cop_mat_a,
  output logic [WIN_BITS-1:0] cop_mat_b,
  input  logic                cop_wait,
  input  logic                cop_done,
  input  logic [31:0]         cop_result,
  output logic                busy,
  output logic                frame_done,
  output logic                op_error
);

  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);

  state_t      state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [4:0]  cnt;
  logic [3:0]  op;
  logic        inb_q;
  logic        inb_qq;

  logic        accept;
  logic        last_x;
  logic        last_px;

  logic          iss;
  logic [XW-1:0] ix;
  logic [YW-1:0] iy;
  logic [4:0]    ik;

  logic              g_inb;
  logic [ADDR_W-1:0] g_addr;

  logic unused_res;

  assign unused_res = ^cop_result[31:8];

  assign accept = (state == S_IDLE)
               && start
               && op_valid(op_sel);
  assign last_x  = (x == XW'(IMG_W - 1));
  assign last_px = last_x
                && (y == YW'(IMG_H - 1));

  // Tap address for the *next* cycle, so the registered
  // src_addr shows tap k during GATHER cycle k.
  always_comb begin
    iss = 1'b0;
    ix  = x;
    iy  = y;
    ik  = '0;
    unique case (1'b1)
      accept: begin
        iss = 1'b1;
        ix  = '0;
        iy  = '0;
      end
      (state == S_NEXT) && !last_px: begin
        iss = 1'b1;
        ix  = last_x ? '0 : x + 1'b1;
        iy  = last_x ? y + 1'b1 : y;
      end
      (state == S_GATHER)
        && (cnt < 5'(TAP_LAST)): begin
        iss = 1'b1;
        ik  = cnt + 5'd1;
      end
      default: ;
    endcase
  end

  ipu_tap_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W),
    .XW     (XW),
    .YW     (YW)
  ) u_tap (
    .x         (ix),
    .y         (iy),
    .k         (ik),
    .in_bounds (g_inb),
    .addr      (g_addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      x            <= '0;
      y            <= '0;
      cnt          <= '0;
      op           <= '0;
      inb_q        <= 1'b0;
      inb_qq       <= 1'b0;
      src_addr     <= '0;
      dst_addr     <= '0;
      dst_data     <= '0;
      dst_we       <= 1'b0;
      cop_instr    <= '0;
      cop_activate <= 1'b0;
      cop_request  <= 1'b0;
      cop_mat_a    <= '0;
      cop_mat_b    <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      op_error     <= 1'b0;
    end else begin
      op_error     <= 1'b0;
      cop_activate <= 1'b0;
      dst_we       <= 1'b0;
      frame_done   <= 1'b0;
      // inb_qq lines up with src_data of the
      // tap whose address was shown last cycle.
      inb_q  <= iss && g_inb;
      inb_qq <= inb_q;
      if (iss && g_inb)
        src_addr <= g_addr;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (op_valid(op_sel)) begin
              op        <= op_sel;
              cop_mat_b <= kernel;
              x         <= '0;
              y         <= '0;
              cnt       <= '0;
              busy      <= 1'b1;
              state     <= S_GATHER;
            end else begin
              op_error <= 1'b1;
            end
          end
        end
        S_GATHER: begin
          for (int i = 0; i < WIN_TAPS; i++) begin
            if (cnt == 5'(i + 1))
              cop_mat_a[8*i +: 8] <=
                inb_qq ? src_data : 8'h00;
          end
          if (cnt == 5'(WIN_TAPS)) begin
            cnt         <= '0;
            cop_request <= 1'b1;
            cop_instr   <= {28'b0, op};
            state       <= S_ISSUE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        S_ISSUE: begin
          if (!cop_wait) begin
            cop_activate <= 1'b1;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cop_done) begin
            cop_request <= 1'b0;
            cop_instr   <= '0;
            dst_we      <= 1'b1;
            dst_data    <= cop_result[7:0];
            dst_addr    <= ADDR_W'(y)
                         * ADDR_W'(IMG_W)
                         + ADDR_W'(x);
            state       <= S_WRITE;
          end
        end
        S_WRITE: begin
          state <= S_NEXT;
        end
        S_NEXT: begin
          if (last_px) begin
            x          <= '0;
            y          <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            state      <= S_DONE;
          end else begin
            x     <= ix;
            y     <= iy;
            state <= S_GATHER;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
